// File: rtl/proc_pkg.sv
// Shared types and instruction-field helpers for the multi-cycle processor core.
//   Contents: opcode and state enums, default parameter values, field-position helpers.
package proc_pkg;

  localparam int unsigned OP_W = 3;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_NUM_REGS = 4;
  localparam int unsigned DEF_IMM_W    = 5;
  localparam int unsigned DEF_PC_W     = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ADDI = 3'b010,
    OP_LD   = 3'b011,
    OP_ST   = 3'b100,
    OP_JMP  = 3'b101,
    OP_BEQZ = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  // Instruction layout, MSB to LSB: op | rd | rs | imm
  function automatic int unsigned instr_width(input int unsigned reg_aw, input int unsigned imm_w);
    return OP_W + 2 * reg_aw + imm_w;
  endfunction

  function automatic int unsigned rs_lsb(input int unsigned imm_w);
    return imm_w;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned reg_aw, input int unsigned imm_w);
    return imm_w + reg_aw;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned reg_aw, input int unsigned imm_w);
    return imm_w + 2 * reg_aw;
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// Register file: NUM_REGS x DATA_W, one synchronous write port, two asynchronous
// read ports and an asynchronous debug read port. All registers reset to zero.
//   clk_i, rst_ni         : clock, async active-low reset
//   we_i/waddr_i/wdata_i  : write port (captured on rising edge)
//   raddr_a_i/rdata_a_c_o : read port A (combinational)
//   raddr_b_i/rdata_b_c_o : read port B (combinational)
//   dbg_raddr_i/dbg_rdata_c_o : debug read port (combinational)
module proc_regfile
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_c_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_c_o,
  input  logic [REG_AW-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_c_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Storage with single write port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_c_o   = regs_q[raddr_a_i];
  assign rdata_b_c_o   = regs_q[raddr_b_i];
  assign dbg_rdata_c_o = regs_q[dbg_raddr_i];

endmodule

// File: rtl/multicycle_proc.sv
// Multi-cycle processor core: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// synchronous-read instruction port and a req/ack data port with wait states.
//   clk, reset (async active-low)
//   imem_addr/imem_rdata : instruction fetch (rdata valid one cycle after addr)
//   dmem_*               : data port, req held until one-cycle ack
//   dbg_addr/dbg_data    : combinational register peek
//   pc, c_flag, halted   : architectural status
module multicycle_proc
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned IMM_W    = DEF_IMM_W,
  parameter int unsigned PC_W     = DEF_PC_W,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS),
  localparam int unsigned INSTR_W = OP_W + 2 * REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [PC_W-1:0]    pc,
  output logic               c_flag,
  output logic               halted
);

  localparam int unsigned RS_LSB = rs_lsb(IMM_W);
  localparam int unsigned RD_LSB = rd_lsb(REG_AW, IMM_W);
  localparam int unsigned OP_LSB = op_lsb(REG_AW, IMM_W);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                carry_q, carry_d;
  logic                c_flag_q, c_flag_d;
  logic                halted_q, halted_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;

  opcode_e             op;
  logic                fetched_halt;
  logic [REG_AW-1:0]   rd_idx, rs_idx;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   imm_data;
  logic [PC_W-1:0]     imm_pc;
  logic [DATA_W-1:0]   rd_val, rs_val;
  logic [DATA_W:0]     alu_sum;
  logic [DATA_W-1:0]   eff_addr;
  logic                rf_we;

  // Field extraction from the latched instruction
  assign op           = opcode_e'(ir_q[OP_LSB +: OP_W]);
  assign fetched_halt = (opcode_e'(imem_rdata[OP_LSB +: OP_W]) == OP_HALT);
  assign rd_idx       = ir_q[RD_LSB +: REG_AW];
  assign rs_idx       = ir_q[RS_LSB +: REG_AW];
  assign imm          = ir_q[IMM_W-1:0];
  assign imm_data     = DATA_W'($signed(imm));
  assign imm_pc       = PC_W'($signed(imm));

  proc_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .REG_AW  (REG_AW)
  ) u_regfile (
    .clk_i        (clk),
    .rst_ni       (reset),
    .we_i         (rf_we),
    .waddr_i      (rd_idx),
    .wdata_i      (res_q),
    .raddr_a_i    (rd_idx),
    .rdata_a_c_o  (rd_val),
    .raddr_b_i    (rs_idx),
    .rdata_b_c_o  (rs_val),
    .dbg_raddr_i  (dbg_addr),
    .dbg_rdata_c_o(dbg_data)
  );

  // ALU with one extra bit: carry for adds, borrow (rd<rs unsigned) for SUB
  always_comb begin
    alu_sum = '0;
    case (op)
      OP_ADD:  alu_sum = {1'b0, rd_val} + {1'b0, rs_val};
      OP_SUB:  alu_sum = {1'b0, rd_val} - {1'b0, rs_val};
      OP_ADDI: alu_sum = {1'b0, rd_val} + {1'b0, imm_data};
      default: alu_sum = '0;
    endcase
  end

  assign eff_addr = rs_val + imm_data;

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    res_d        = res_q;
    carry_d      = carry_q;
    c_flag_d     = c_flag_q;
    halted_d     = halted_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we        = 1'b0;

    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        ir_d = imem_rdata;
        if (fetched_halt) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_ADDI: begin
            res_d   = alu_sum[DATA_W-1:0];
            carry_d = alu_sum[DATA_W];
            state_d = S_WB;
          end
          OP_LD, OP_ST: begin
            dmem_req_d  = 1'b1;
            dmem_we_d   = (op == OP_ST);
            dmem_addr_d = eff_addr;
            if (op == OP_ST) begin
              dmem_wdata_d = rd_val;
            end
            state_d = S_MEM;
          end
          OP_JMP: begin
            pc_d    = pc_q + imm_pc;
            state_d = S_FETCH;
          end
          OP_BEQZ: begin
            pc_d    = (rd_val == '0) ? (pc_q + imm_pc) : (pc_q + PC_W'(1));
            state_d = S_FETCH;
          end
          default: begin
            // HALT is caught in DECODE; kept here so every opcode has a target
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we = 1'b1;
        if (op == OP_ADD || op == OP_SUB || op == OP_ADDI) begin
          c_flag_d = carry_q;
        end
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      c_flag_q     <= 1'b0;
      halted_q     <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      c_flag_q     <= c_flag_d;
      halted_q     <= halted_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign c_flag     = c_flag_q;
  assign halted     = halted_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_multicycle_proc.sv
// Testbench for multicycle_proc: directed test-plan programs plus random programs,
// checked against an instruction-level reference model with per-op latencies.
module tb_multicycle_proc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  imem_addr;
  logic [11:0] imem_rdata = '0;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic [7:0]  dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data, pc;
  logic        c_flag, halted;

  multicycle_proc #(.DATA_W(8), .NUM_REGS(4), .IMM_W(5), .PC_W(8)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .pc(pc), .c_flag(c_flag), .halted(halted)
  );

  always #10 clk = ~clk;

  logic [11:0] imem [256];
  logic [7:0]  dmem [256];

  // Synchronous-read instruction memory
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  // Data memory responder: ack after wait_cycles extra cycles, watches stability
  int   wait_cycles = 0, mem_cnt = 0, req_cycles = 0, stable_err = 0, acks = 0;
  bit   in_txn = 0, stray_ack = 0;
  logic [7:0] txn_addr, txn_wdata, txn_pc, last_addr, last_wdata;
  logic txn_we, last_we;

  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      req_cycles++;
      if (!in_txn) begin
        in_txn = 1; mem_cnt = 0;
        txn_addr = dmem_addr; txn_wdata = dmem_wdata; txn_we = dmem_we; txn_pc = pc;
      end else if (dmem_addr !== txn_addr || dmem_wdata !== txn_wdata ||
                   dmem_we !== txn_we || pc !== txn_pc) begin
        stable_err++;
      end
      if (mem_cnt == wait_cycles) begin
        dmem_ack = 1'b1; acks++;
        last_addr = dmem_addr; last_we = dmem_we; last_wdata = dmem_wdata;
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        else dmem_rdata = dmem[dmem_addr];
      end else begin
        dmem_ack = 1'b0;
      end
      mem_cnt++;
    end else begin
      in_txn = 0;
      dmem_ack = stray_ack;
    end
  end

  // Reference model state (architectural view only)
  int m_r [4];
  int m_pc, m_c;
  bit m_halted;
  int m_mem [256];

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] enc(input int op, input int rd, input int rs, input int imm);
    return {op[2:0], rd[1:0], rs[1:0], imm[4:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0; m_c = 0; m_halted = 0;
  endtask

  task automatic check_state();
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("c_flag", c_flag, m_c);
    check("halted", halted, m_halted);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = i[1:0];
      #1;
      check($sformatf("r%0d", i), dbg_data, m_r[i]);
    end
  endtask

  task automatic read_reg(input int idx, output logic [7:0] val);
    dbg_addr = idx[1:0];
    #1;
    val = dbg_data;
  endtask

  // Reset pulse between clock edges; reset values checked while asserted
  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0; stray_ack = 0; wait_cycles = 0;
    #1;
    check("rst_pc", pc, 0);
    check("rst_c", c_flag, 0);
    check("rst_halted", halted, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // Execute one instruction in the model, wait its latency, compare
  task automatic run_instr(input int w);
    logic [11:0] ins;
    int op, rd, rs, imm, ea, lat, s;
    bit is_mem;
    ins = imem[m_pc];
    op = int'(ins[11:9]); rd = int'(ins[8:7]); rs = int'(ins[6:5]); imm = int'(ins[4:0]);
    if (imm >= 16) imm -= 32;
    wait_cycles = w; req_cycles = 0; stable_err = 0; acks = 0; is_mem = 0; ea = 0;
    case (op)
      0: begin s = m_r[rd] + m_r[rs]; m_c = (s > 255); m_r[rd] = s % 256; lat = 4; m_pc = (m_pc + 1) % 256; end
      1: begin m_c = (m_r[rd] < m_r[rs]); m_r[rd] = (m_r[rd] - m_r[rs] + 256) % 256; lat = 4; m_pc = (m_pc + 1) % 256; end
      2: begin s = m_r[rd] + (imm + 256) % 256; m_c = (s > 255); m_r[rd] = s % 256; lat = 4; m_pc = (m_pc + 1) % 256; end
      3: begin ea = (m_r[rs] + imm + 256) % 256; m_r[rd] = m_mem[ea]; lat = 5 + w; is_mem = 1; m_pc = (m_pc + 1) % 256; end
      4: begin ea = (m_r[rs] + imm + 256) % 256; m_mem[ea] = m_r[rd]; lat = 4 + w; is_mem = 1; m_pc = (m_pc + 1) % 256; end
      5: begin m_pc = (m_pc + imm + 256) % 256; lat = 3; end
      6: begin m_pc = (m_r[rd] == 0) ? (m_pc + imm + 256) % 256 : (m_pc + 1) % 256; lat = 3; end
      default: begin m_halted = 1; lat = 2; end
    endcase
    repeat (lat) @(posedge clk);
    #1;
    check_state();
    if (is_mem) begin
      check("req_cycles", req_cycles, w + 1);
      check("mem_stable", stable_err, 0);
      check("mem_acks", acks, 1);
      check("mem_addr", last_addr, ea);
      check("mem_we", last_we, (op == 4));
      if (op == 4) check("mem_wdata", last_wdata, m_r[rd]);
    end
  endtask

  task automatic fill_imem_halt();
    for (int i = 0; i < 256; i++) imem[i] = enc(7, 0, 0, 0);
  endtask

  task automatic fill_dmem_random();
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'($urandom);
      m_mem[i] = int'(dmem[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    fill_imem_halt();
    fill_dmem_random();
    model_reset();

    // ADDI pair, then BEQZ back to 0
    imem[0] = enc(2, 1, 0, 5);
    imem[1] = enc(2, 1, 0, -1);
    imem[2] = enc(2, 2, 0, 3);
    imem[3] = enc(6, 0, 0, -3);
    do_reset();
    run_instr(0);
    run_instr(0);
    read_reg(1, v);
    check("tp_addi_r1", v, 8'h04);
    check("tp_addi_pc", pc, 2);
    check("tp_addi_c", c_flag, 1);
    run_instr(0);
    run_instr(0);
    check("tp_beqz_taken_pc", pc, 0);

    // ADD/SUB carry and borrow, LD, delayed ST, LD back
    fill_imem_halt();
    imem[0] = enc(2, 1, 0, -1);
    imem[1] = enc(2, 2, 0, 1);
    imem[2] = enc(0, 1, 2, 0);
    imem[3] = enc(1, 1, 2, 0);
    imem[4] = enc(3, 1, 0, 15);
    imem[5] = enc(2, 2, 0, 15);
    imem[6] = enc(4, 1, 2, 2);
    imem[7] = enc(3, 3, 2, 2);
    dmem[15] = 8'hA5; m_mem[15] = 'hA5;
    do_reset();
    run_instr(0);
    run_instr(0);
    run_instr(0);
    read_reg(1, v);
    check("tp_add_r1", v, 8'h00);
    check("tp_add_c", c_flag, 1);
    run_instr(0);
    read_reg(1, v);
    check("tp_sub_r1", v, 8'hFF);
    check("tp_sub_borrow", c_flag, 1);
    run_instr(1);
    run_instr(0);
    run_instr(3);
    check("tp_st_req_cycles", req_cycles, 4);
    check("tp_st_addr", last_addr, 8'h12);
    check("tp_st_wdata", last_wdata, 8'hA5);
    check("tp_st_mem", dmem[8'h12], 8'hA5);
    run_instr(2);
    read_reg(3, v);
    check("tp_ld_r3", v, 8'hA5);

    // BEQZ not taken, JMP to 0xFF, JMP wrapping to 0x00
    fill_imem_halt();
    imem[0] = enc(2, 0, 0, 1);
    imem[1] = enc(2, 1, 0, 1);
    imem[2] = enc(2, 1, 0, 1);
    imem[3] = enc(6, 0, 0, 5);
    imem[4] = enc(5, 0, 0, -5);
    imem[255] = enc(5, 0, 0, 1);
    do_reset();
    repeat (4) run_instr(0);
    check("tp_beqz_not_taken_pc", pc, 4);
    run_instr(0);
    check("tp_jmp_back_pc", pc, 8'hFF);
    run_instr(0);
    check("tp_jmp_wrap_pc", pc, 8'h00);
    run_instr(0);

    // HALT at pc=5 with a stray ack
    fill_imem_halt();
    for (int i = 0; i < 5; i++) imem[i] = enc(2, $urandom_range(0, 3), 0, $urandom_range(0, 31));
    imem[5] = enc(7, 0, 0, 0);
    do_reset();
    repeat (6) run_instr(0);
    check("tp_halt_flag", halted, 1);
    stray_ack = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("halt_req", dmem_req, 0);
      check("halt_pc", pc, 5);
      check("halt_flag", halted, 1);
    end
    check_state();
    stray_ack = 0;

    // Reset asserted during a long MEM wait
    fill_imem_halt();
    imem[0] = enc(2, 1, 0, 3);
    imem[1] = enc(4, 1, 1, 2);
    imem[2] = enc(2, 2, 0, 1);
    do_reset();
    run_instr(0);
    wait_cycles = 20;
    repeat (5) @(posedge clk);
    #3;
    check("mid_mem_req", dmem_req, 1);
    check("mid_mem_addr", dmem_addr, 5);
    reset = 1'b0;
    #1;
    check("async_req", dmem_req, 0);
    check("async_we", dmem_we, 0);
    check("async_addr", dmem_addr, 0);
    check("async_wdata", dmem_wdata, 0);
    check("async_pc", pc, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    check_state();
    run_instr(0);

    // Random programs (HALT replaced by ADDI) with random wait states
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 256; i++) begin
        imem[i] = 12'($urandom);
        if (imem[i][11:9] == 3'b111) imem[i][11:9] = 3'b010;
      end
      fill_dmem_random();
      do_reset();
      for (int k = 0; k < 60; k++) run_instr($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
